hatch_arbiter: RTL and testbench

Round-robin arbiter sharing the single-ported instruction memory (the "hatch") between N fetch requesters, e.g. the fetch stages of several CPU cores or a core plus a loader. It grants at most one read per cycle, tracks each in-flight read through a fixed-latency tag pipeline, and routes the returned 48-bit instruction back to the requester that issued it. A per-requester flush drops that requester's in-flight responses, matching a fetch stage discarding fetches on a kill.

---
 rtl/hatch_arbiter.sv | 109 ++++++++++
 tb/tb_hatch_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hatch_arbiter.sv
// hatch_arbiter: round-robin arbiter sharing the single-ported instruction
// memory between N fetch requesters. One read is granted per cycle. Each read
// is tracked through a fixed-latency tag pipeline so that the returned
// instruction reaches the requester that issued it. A per-requester flush
// drops that requester's in-flight responses.
module hatch_arbiter #(
  parameter int N   = 2,
  parameter int LAT = 1,
  parameter int AW  = 32,
  parameter int IW  = 48
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*AW-1:0] req_address,
  output logic [N-1:0]    req_ready,
  input  logic [N-1:0]    flush,
  output logic [AW-1:0]   hatch_address,
  output logic            hatch_valid,
  input  logic [IW-1:0]   hatch_instruction,
  output logic [N-1:0]    resp_valid,
  output logic [IW-1:0]   resp_instruction
);

  localparam int          IDW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned NU  = N;

  logic [IDW-1:0] rr_ptr;
  logic [AW-1:0]  last_addr;
  logic [N-1:0]   eligible;
  logic           grant_any;
  logic [IDW-1:0] grant_id;
  logic [LAT-1:0] pipe_v;
  logic [IDW-1:0] pipe_id [LAT];
  logic           out_live;

  // True when the tag id belongs to a requester being flushed this cycle.
  function automatic logic id_flushed(input logic [IDW-1:0] id,
                                      input logic [N-1:0]   f);
    logic hit;
    hit = 1'b0;
    for (int unsigned j = 0; j < NU; j++) begin
      if (f[j] && id == IDW'(j)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Round-robin grant: first eligible requester at or after rr_ptr, wrapping.
  always_comb begin : grant_sel
    int unsigned idx;
    idx       = 0;
    eligible  = rst ? '0 : (req_valid & ~flush);
    grant_any = 1'b0;
    grant_id  = '0;
    req_ready = '0;
    for (int unsigned k = 0; k < NU; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NU) idx = idx - NU;
      if (!grant_any && eligible[idx[IDW-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = idx[IDW-1:0];
      end
    end
    if (grant_any) req_ready[grant_id] = 1'b1;
    hatch_valid = grant_any;
    if (rst)
      hatch_address = '0;
    else if (grant_any)
      hatch_address = req_address[grant_id*AW +: AW];
    else
      hatch_address = last_addr;
  end

  // Advance the round-robin pointer and remember the last issued address.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      last_addr <= '0;
    end else if (grant_any) begin
      rr_ptr    <= (32'(grant_id) == NU - 1) ? '0 : grant_id + 1'b1;
      last_addr <= hatch_address;
    end
  end

  // Tag pipeline; a flush clears matching entries as they shift forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_v <= '0;
    end else begin
      pipe_v[0] <= grant_any;
      for (int unsigned s = 1; s < LAT; s++) begin
        pipe_v[s] <= pipe_v[s-1] & ~id_flushed(pipe_id[s-1], flush);
      end
    end
    pipe_id[0] <= grant_id;
    for (int unsigned s = 1; s < LAT; s++) begin
      pipe_id[s] <= pipe_id[s-1];
    end
  end

  // Response routing; a flush suppresses the matching response in the same cycle.
  always_comb begin
    out_live   = !rst && pipe_v[LAT-1] && !id_flushed(pipe_id[LAT-1], flush);
    resp_valid = '0;
    if (out_live) resp_valid[pipe_id[LAT-1]] = 1'b1;
    resp_instruction = out_live ? hatch_instruction : '0;
  end

endmodule

// File: tb/tb_hatch_arbiter.sv
// Self-checking bench for hatch_arbiter: three N=2 instances with LAT=1,2,3
// share one stimulus stream and are compared against a scoreboard model.
module tb_hatch_arbiter;

  localparam int ND = 3;
  localparam int NR = 2;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_address;
  logic [1:0]  flush;
  logic [47:0] hatch_instruction;

  logic [1:0]  rdy   [ND];
  logic [31:0] haddr [ND];
  logic        hv    [ND];
  logic [1:0]  rv    [ND];
  logic [47:0] rinst [ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    hatch_arbiter #(.N(2), .LAT(g + 1), .AW(32), .IW(48)) u_dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_address      (req_address),
      .req_ready        (rdy[g]),
      .flush            (flush),
      .hatch_address    (haddr[g]),
      .hatch_valid      (hv[g]),
      .hatch_instruction(hatch_instruction),
      .resp_valid       (rv[g]),
      .resp_instruction (rinst[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dut;
    int id;
    int due;
    bit alive;
  } rec_t;

  rec_t        inflight[$];
  int          ptr  [ND];
  logic [31:0] last [ND];
  int          cyc;
  int          g0;
  int          n_tests;
  int          n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Scoreboard step for one instance: applies flush/reset rules to the set of
  // outstanding reads, picks the grant, and compares every output.
  task automatic model_dut(input int d);
    int          lat;
    int          grant;
    int          idx;
    logic [1:0]  e;
    logic [1:0]  exp_rdy;
    logic [1:0]  exp_rv;
    logic [47:0] exp_ri;
    logic [31:0] exp_ad;
    lat = d + 1;
    if (rst) begin
      check($sformatf("rst_rdy%0d", d), 64'(rdy[d]), 64'd0);
      check($sformatf("rst_hv%0d", d), 64'(hv[d]), 64'd0);
      check($sformatf("rst_haddr%0d", d), 64'(haddr[d]), 64'd0);
      check($sformatf("rst_rv%0d", d), 64'(rv[d]), 64'd0);
      check($sformatf("rst_rinst%0d", d), 64'(rinst[d]), 64'd0);
      for (int i = inflight.size() - 1; i >= 0; i--)
        if (inflight[i].dut == d) inflight.delete(i);
      ptr[d]  = 0;
      last[d] = '0;
      if (d == 0) g0 = -1;
      return;
    end
    for (int i = 0; i < inflight.size(); i++)
      if (inflight[i].dut == d && flush[inflight[i].id]) inflight[i].alive = 0;
    e     = req_valid & ~flush;
    grant = -1;
    for (int k = 0; k < NR; k++) begin
      idx = (ptr[d] + k) % NR;
      if (grant < 0 && e[idx]) grant = idx;
    end
    exp_rdy = (grant >= 0) ? 2'(1 << grant) : 2'b00;
    exp_rv  = 2'b00;
    for (int i = inflight.size() - 1; i >= 0; i--) begin
      if (inflight[i].dut == d && inflight[i].due == cyc) begin
        if (inflight[i].alive) exp_rv = 2'(1 << inflight[i].id);
        inflight.delete(i);
      end
    end
    exp_ri = (exp_rv != 2'b00) ? hatch_instruction : 48'd0;
    exp_ad = (grant >= 0) ? req_address[grant*32 +: 32] : last[d];
    check($sformatf("rdy%0d", d), 64'(rdy[d]), 64'(exp_rdy));
    check($sformatf("hv%0d", d), 64'(hv[d]), 64'(grant >= 0));
    check($sformatf("haddr%0d", d), 64'(haddr[d]), 64'(exp_ad));
    check($sformatf("rv%0d", d), 64'(rv[d]), 64'(exp_rv));
    check($sformatf("rinst%0d", d), 64'(rinst[d]), 64'(exp_ri));
    if (grant >= 0) begin
      inflight.push_back('{dut: d, id: grant, due: cyc + lat, alive: 1'b1});
      ptr[d]  = (grant + 1) % NR;
      last[d] = exp_ad;
    end
    if (d == 0) g0 = grant;
  endtask

  task automatic step(input logic r, input logic [1:0] v, input logic [63:0] a,
                      input logic [1:0] f, input logic [47:0] hi);
    rst               = r;
    req_valid         = v;
    req_address       = a;
    flush             = f;
    hatch_instruction = hi;
    #4;
    for (int d = 0; d < ND; d++) model_dut(d);
  endtask

  task automatic tick();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 2'b00, {$urandom, $urandom}, 2'b00, 48'({$urandom, $urandom}));
      tick();
    end
  endtask

  logic [1:0]  cur_v;
  logic [63:0] cur_a;
  logic [1:0]  cur_f;
  logic        cur_r;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    g0      = -1;
    for (int d = 0; d < ND; d++) begin
      ptr[d]  = 0;
      last[d] = '0;
    end
    rst = 1'b1; req_valid = 2'b11; req_address = '0; flush = '0; hatch_instruction = '0;
    @(posedge clk);
    #1;

    // Reset with both requesters asserting, then first grant goes to 0.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b11, 64'h0000_0002_0000_0001, 2'b00, 48'h1234);
      tick();
    end
    step(1'b0, 2'b11, 64'h0000_0002_0000_0001, 2'b00, 48'h0);
    check("first_grant", 64'(rdy[0]), 64'h1);
    tick();
    idle(4);

    // Single requester 1 at 0x10, instruction returned next cycle.
    step(1'b0, 2'b10, 64'h0000_0010_0000_0000, 2'b00, 48'h0);
    check("single_haddr", 64'(haddr[0]), 64'h10);
    check("single_hv", 64'(hv[0]), 64'h1);
    tick();
    step(1'b0, 2'b00, 64'h0, 2'b00, 48'hABCDEF012345);
    check("single_rv", 64'(rv[0]), 64'h2);
    check("single_rinst", 64'(rinst[0]), 64'hABCDEF012345);
    tick();
    idle(4);

    // Contention: grants alternate 0,1,0,1,0,1.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 2'b11, {32'h2000 + 32'(i), 32'h1000 + 32'(i)}, 2'b00,
           48'({$urandom, $urandom}));
      check("alt_grant", 64'(rdy[0]), (i % 2 == 0) ? 64'h1 : 64'h2);
      tick();
    end
    idle(4);

    // Flush on the LAT=3 instance: three issues from 0, then flush[0].
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 2'b01, {32'h0, 32'h300 + 32'(i)}, 2'b00, 48'({$urandom, $urandom}));
      tick();
    end
    step(1'b0, 2'b10, 64'h0000_0500_0000_0000, 2'b01, 48'h111);
    check("flush_rv_t3", 64'(rv[2][0]), 64'h0);
    check("flush_grant1", 64'(rdy[2]), 64'h2);
    tick();
    for (int i = 4; i < 6; i++) begin
      step(1'b0, 2'b00, 64'h0, 2'b00, 48'h222);
      check("flush_rv_tail", 64'(rv[2][0]), 64'h0);
      tick();
    end
    step(1'b0, 2'b00, 64'h0, 2'b00, 48'h333);
    check("flush_rv1", 64'(rv[2]), 64'h2);
    tick();
    idle(4);

    // Reset in flight on the LAT=2 instance.
    step(1'b0, 2'b01, 64'h0000_0000_0000_0700, 2'b00, 48'h0);
    tick();
    step(1'b1, 2'b00, 64'h0, 2'b00, 48'h444);
    tick();
    step(1'b0, 2'b11, 64'h0000_0720_0000_0710, 2'b00, 48'h555);
    check("midrst_rv", 64'(rv[1]), 64'h0);
    check("midrst_ptr", 64'(rdy[1]), 64'h1);
    tick();
    idle(4);

    // Idle hold of the last address.
    step(1'b0, 2'b01, 64'h0000_0000_0000_0040, 2'b00, 48'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'b00, {$urandom, $urandom}, 2'b00, 48'h0);
      for (int d = 0; d < ND; d++) begin
        check("hold_addr", 64'(haddr[d]), 64'h40);
        check("hold_hv", 64'(hv[d]), 64'h0);
      end
      tick();
    end

    // Random traffic: ungranted requests are held until granted.
    cur_v = 2'b00;
    cur_a = '0;
    for (int n = 0; n < 600; n++) begin
      cur_r = ($urandom_range(0, 59) == 0);
      cur_f = 2'b00;
      for (int i = 0; i < NR; i++) cur_f[i] = ($urandom_range(0, 7) == 0);
      step(cur_r, cur_v, cur_a, cur_f, 48'({$urandom, $urandom}));
      for (int i = 0; i < NR; i++) begin
        if (!cur_v[i] || g0 == i || cur_f[i]) begin
          cur_v[i]          = ($urandom_range(0, 2) != 0);
          cur_a[i*32 +: 32] = $urandom;
        end
      end
      tick();
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
